// File: rtl/csr_test_master_pkg.sv
// rtl/csr_test_master_pkg.sv - shared FSM encoding and sizing helper for the CSR test master
package csr_test_master_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      FINISH  = 2'd2,
      RECOVER = 2'd3
   } state_t;

   // A single-register bank still needs a one-bit index.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/csr_read_mux.sv
// rtl/csr_read_mux.sv - selects one register slice from the concatenated read-back bus
module csr_read_mux
   import csr_test_master_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 8,
   parameter int SEL_WIDTH  = sel_width(NUM_REGS)
) (
   input  logic [SEL_WIDTH-1:0]           sel,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0]          data_out
);

   // Out-of-range indices match no slice and read back as zero.
   always_comb begin
      data_out = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (sel == SEL_WIDTH'(i)) begin
            data_out = data_in[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/csr_test_master.sv
// rtl/csr_test_master.sv - single-outstanding CSR bus master turning one command into a strobed bus cycle
module csr_test_master
   import csr_test_master_pkg::*;
#(
   parameter int CSR_DATA_BUS_WIDTH   = 32,
   parameter int CSR_STROBE_BUS_WIDTH = 8,
   parameter int SEL_WIDTH            = sel_width(CSR_STROBE_BUS_WIDTH)
) (
   input  logic                                             clk,
   input  logic                                             rst_n,
   output logic                                             ready,
   input  logic                                             cmd_valid,
   input  logic                                             cmd_rw,
   input  logic [SEL_WIDTH-1:0]                             cmd_sel,
   input  logic [CSR_DATA_BUS_WIDTH-1:0]                    cmd_wdata,
   output logic [CSR_STROBE_BUS_WIDTH-1:0]                  csr_stb_o,
   output logic [CSR_DATA_BUS_WIDTH-1:0]                    csr_data_o,
   input  logic [CSR_STROBE_BUS_WIDTH*CSR_DATA_BUS_WIDTH-1:0] csr_data_i,
   output logic                                             csr_rw,
   output logic                                             csr_in_progress,
   output logic [CSR_DATA_BUS_WIDTH-1:0]                    rdata,
   output logic                                             rdata_valid
);

   state_t                          state, next_state;
   logic [SEL_WIDTH-1:0]            sel_q;
   logic [CSR_DATA_BUS_WIDTH-1:0]   mux_data;
   logic                            accept;

   assign accept = cmd_valid && ready;

   csr_read_mux #(
      .DATA_WIDTH (CSR_DATA_BUS_WIDTH),
      .NUM_REGS   (CSR_STROBE_BUS_WIDTH),
      .SEL_WIDTH  (SEL_WIDTH)
   ) u_read_mux (
      .sel      (sel_q),
      .data_in  (csr_data_i),
      .data_out (mux_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = ACCESS;
         ACCESS:  next_state = FINISH;
         FINISH:  next_state = RECOVER;
         RECOVER: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      csr_in_progress = (state == ACCESS) || (state == FINISH);
      csr_stb_o       = '0;
      if ((state == ACCESS) && csr_rw) begin
         for (int i = 0; i < CSR_STROBE_BUS_WIDTH; i++) begin
            csr_stb_o[i] = (sel_q == SEL_WIDTH'(i));
         end
      end
   end

   // ready is registered so it stays low through reset and rises one edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready       <= 1'b0;
         csr_rw      <= 1'b0;
         sel_q       <= '0;
         csr_data_o  <= '0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
      end else begin
         ready       <= (next_state == IDLE);
         rdata_valid <= (state == FINISH) && !csr_rw;
         if (accept) begin
            csr_rw     <= cmd_rw;
            sel_q      <= cmd_sel;
            csr_data_o <= cmd_wdata;
         end
         if ((state == FINISH) && !csr_rw) begin
            rdata <= mux_data;
         end
      end
   end

endmodule

// File: tb/tb_csr_test_master.sv
// tb/tb_csr_test_master.sv - scoreboard bench for csr_test_master
module tb_csr_test_master;

   localparam int DW = 32;
   localparam int NR = 8;
   localparam int SW = 3;

   typedef struct {
      logic        rw;
      int          sel;
      logic [31:0] d;
      logic [31:0] rd;
   } exp_t;

   logic               clk;
   logic               rst_n;
   logic               ready;
   logic               cmd_valid;
   logic               cmd_rw;
   logic [SW-1:0]      cmd_sel;
   logic [DW-1:0]      cmd_wdata;
   logic [NR-1:0]      csr_stb_o;
   logic [DW-1:0]      csr_data_o;
   logic [NR*DW-1:0]   csr_data_i;
   logic               csr_rw;
   logic               csr_in_progress;
   logic [DW-1:0]      rdata;
   logic               rdata_valid;

   logic [DW-1:0]      bank [NR];
   logic [DW-1:0]      mdl  [NR];
   logic               bank_clr;
   logic               load_en;
   int                 load_idx;
   logic [DW-1:0]      load_val;

   exp_t               q[$];
   int                 n_chk;
   int                 n_err;
   int                 cyc;
   int                 acc_cnt;
   int                 last_acc;
   int                 win_len;
   int                 low_cnt;
   int                 due;
   logic               have_acc;
   logic               have_win;
   logic               prev_ip;
   logic               pend;
   logic [DW-1:0]      exp_rd;

   csr_test_master #(
      .CSR_DATA_BUS_WIDTH   (DW),
      .CSR_STROBE_BUS_WIDTH (NR),
      .SEL_WIDTH            (SW)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ready           (ready),
      .cmd_valid       (cmd_valid),
      .cmd_rw          (cmd_rw),
      .cmd_sel         (cmd_sel),
      .cmd_wdata       (cmd_wdata),
      .csr_stb_o       (csr_stb_o),
      .csr_data_o      (csr_data_o),
      .csr_data_i      (csr_data_i),
      .csr_rw          (csr_rw),
      .csr_in_progress (csr_in_progress),
      .rdata           (rdata),
      .rdata_valid     (rdata_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bank_clr) begin
         for (int i = 0; i < NR; i++) bank[i] <= '0;
      end else if (load_en) begin
         bank[load_idx] <= load_val;
      end else begin
         for (int i = 0; i < NR; i++) if (csr_stb_o[i]) bank[i] <= csr_data_o;
      end
   end

   always_comb begin
      csr_data_i = '0;
      for (int i = 0; i < NR; i++) csr_data_i[i*DW +: DW] = bank[i];
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Bus monitor: pops one expectation per in_progress window.
   initial begin
      exp_t e;
      cyc = 0; acc_cnt = 0; last_acc = 0; win_len = 0; low_cnt = 0; due = 0;
      have_acc = 0; have_win = 0; prev_ip = 0; pend = 0; exp_rd = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            prev_ip = 0; pend = 0; have_win = 0; have_acc = 0; low_cnt = 0;
         end else begin
            if (cmd_valid && ready) begin
               acc_cnt++;
               if (have_acc) check("accept_spacing", 64'((cyc - last_acc) >= 4), 1);
               have_acc = 1;
               last_acc = cyc;
            end
            if (csr_in_progress && !prev_ip) begin
               if (have_win) check("idle_gap", 64'(low_cnt >= 2), 1);
               have_win = 1;
               win_len  = 1;
               if (q.size() == 0) begin
                  check("unexpected_txn", 1, 0);
               end else begin
                  e = q.pop_front();
                  check("csr_rw", csr_rw, e.rw);
                  check("strobe", csr_stb_o, e.rw ? (64'd1 << e.sel) : 64'd0);
                  if (e.rw) begin
                     check("wdata", csr_data_o, e.d);
                  end else begin
                     pend   = 1;
                     due    = cyc + 2;
                     exp_rd = e.rd;
                  end
               end
            end else if (csr_in_progress) begin
               win_len++;
               check("strobe_late", csr_stb_o, 0);
            end else begin
               if (prev_ip) begin
                  check("window_len", win_len, 2);
                  low_cnt = 1;
               end else begin
                  low_cnt++;
               end
               check("strobe_idle", csr_stb_o, 0);
            end
            if (pend && cyc == due) begin
               check("rdata_valid", rdata_valid, 1);
               check("rdata", rdata, exp_rd);
               pend = 0;
            end else if (rdata_valid) begin
               check("rdata_valid_spurious", 1, 0);
            end
            prev_ip = csr_in_progress;
         end
      end
   end

   // Callers sit 1 time unit after a rising edge.
   task automatic issue(input logic rw, input int sel, input logic [31:0] d);
      int n;
      exp_t e;
      n = 0;
      while (!ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ready) begin
         check("ready_timeout", 0, 1);
         return;
      end
      cmd_rw    = rw;
      cmd_sel   = SW'(sel);
      cmd_wdata = d;
      cmd_valid = 1'b1;
      e.rw  = rw;
      e.sel = sel;
      e.d   = d;
      e.rd  = rw ? 32'd0 : mdl[sel];
      q.push_back(e);
      if (rw) mdl[sel] = d;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || pend || !ready) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_timeout", 64'(n < 100), 1);
   endtask

   task automatic preload(input int idx, input logic [31:0] v);
      bank_clr = 1'b1;
      @(posedge clk); #1;
      bank_clr = 1'b0;
      load_en  = 1'b1;
      load_idx = idx;
      load_val = v;
      @(posedge clk); #1;
      load_en  = 1'b0;
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      mdl[idx] = v;
   endtask

   initial begin
      int a0;
      n_chk = 0; n_err = 0;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_sel = '0; cmd_wdata = '0;
      bank_clr = 1'b1; load_en = 1'b0; load_idx = 0; load_val = '0;
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      repeat (3) @(posedge clk); #1;
      bank_clr = 1'b0;
      check("rst_ready", ready, 0);
      check("rst_stb", csr_stb_o, 0);
      check("rst_data_o", csr_data_o, 0);
      check("rst_rw", csr_rw, 0);
      check("rst_in_progress", csr_in_progress, 0);
      check("rst_rdata", rdata, 0);
      check("rst_rdata_valid", rdata_valid, 0);
      rst_n = 1'b1;
      check("ready_before_edge", ready, 0);
      @(posedge clk); #1;
      check("ready_after_release", ready, 1);

      issue(1'b1, 3, 32'h2A7);
      drain();
      check("bank3_written", bank[3], 32'h2A7);

      preload(5, 32'h1F3);
      issue(1'b0, 5, 32'h0);
      drain();
      check("read5_held", rdata, 32'h1F3);
      check("read5_rw", csr_rw, 0);

      preload(0, 32'h0);
      for (int i = 0; i < 10; i++) issue(1'b1, int'($urandom % 8), 32'($urandom % 1000));
      for (int i = 0; i < 10; i++) issue(1'b0, int'($urandom % 8), 32'($urandom % 1000));
      drain();

      // cmd_valid held for 9 edges: accepts land on edges 0, 4 and 8 only.
      a0 = acc_cnt;
      cmd_rw = 1'b1; cmd_sel = 3'd2; cmd_wdata = 32'h155; cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         e.rw = 1'b1; e.sel = 2; e.d = 32'h155; e.rd = '0;
         q.push_back(e);
      end
      mdl[2] = 32'h155;
      repeat (9) @(posedge clk); #1;
      cmd_valid = 1'b0;
      drain();
      check("held_valid_accepts", acc_cnt - a0, 3);
      check("bank2_written", bank[2], 32'h155);

      preload(5, 32'h3C5);
      issue(1'b0, 5, 32'h0);
      drain();
      check("pre_reset_rdata", rdata, 32'h3C5);
      cmd_rw = 1'b0; cmd_sel = 3'd5; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("abort_in_access", csr_in_progress, 1);
      rst_n = 1'b0;
      #1;
      check("abort_in_progress", csr_in_progress, 0);
      check("abort_stb", csr_stb_o, 0);
      check("abort_rdata", rdata, 0);
      check("abort_rdata_valid", rdata_valid, 0);
      check("abort_ready", ready, 0);
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort_ready_back", ready, 1);
      repeat (6) @(posedge clk); #1;
      check("abort_rdata_after", rdata, 0);
      check("queue_empty", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
